// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multi-cycle RISC-V style control FSM with memory handshake
module multi_cycle_controller #(
  parameter int ALU_CTRL_W = 4,
  parameter int WAIT_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic funct7b5,
  input  logic zero,
  input  logic mem_ready,
  output logic pc_write,
  output logic adr_src,
  output logic mem_write,
  output logic ir_write,
  output logic reg_write,
  output logic instr_done,
  output logic illegal,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0] state
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7,
                         EXECI = 4'd8, JAL = 4'd9, BRANCH = 4'd10, JALR = 4'd11,
                         LUI = 4'd12, TRAP = 4'd13;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  logic [3:0] nxt;
  logic [2:0] fn, alu_f;
  logic rdy, jalr_q, done_q;
  assign rdy = mem_ready | (WAIT_EN == 0);
  assign fn = funct3 == 3'b000 ? {2'b00, state == EXECR && funct7b5} :
              funct3 == 3'b111 ? 3'd2 : funct3 == 3'b110 ? 3'd3 :
              funct3 == 3'b100 ? 3'd4 : funct3 == 3'b010 ? 3'd5 :
              funct3 == 3'b001 ? 3'd6 : funct3 == 3'b101 ? 3'd7 : 3'd0;
  always_comb begin
    nxt = TRAP;
    case (state)
      FETCH: nxt = rdy ? DECODE : FETCH;
      DECODE: nxt = (op == OP_LOAD || op == OP_STORE) ? MEMADR : op == OP_R ? EXECR :
                    op == OP_I ? EXECI : op == OP_JAL ? JAL : op == OP_BR ? BRANCH :
                    op == OP_JALR ? JALR : op == OP_LUI ? LUI : TRAP;
      MEMADR: nxt = op == OP_STORE ? MEMWRITE : MEMREAD;
      MEMREAD: nxt = rdy ? MEMWB : MEMREAD;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      MEMWB, ALUWB, LUI: nxt = FETCH;
      EXECR, EXECI: nxt = funct3 == 3'b011 ? TRAP : ALUWB;
      JAL, JALR: nxt = ALUWB;
      BRANCH: nxt = funct3[2:1] == 2'b00 ? FETCH : TRAP;
      default: nxt = TRAP;
    endcase
  end
  // Every output is forced low while rst is asserted, independent of the clock
  always_comb begin
    pc_write = 1'b0;
    adr_src = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    illegal = 1'b0;
    result_src = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    imm_src = 3'd0;
    alu_f = 3'd0;
    instr_done = rst & done_q;
    if (rst)
      case (state)
        FETCH: begin
          ir_write = rdy;
          pc_write = rdy;
          alu_src_b = 2'd2;
          result_src = 2'd2;
        end
        DECODE: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src = 3'd2;
        end
        MEMADR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          imm_src = op == OP_STORE ? 3'd1 : 3'd0;
        end
        MEMREAD: adr_src = 1'b1;
        MEMWB: begin
          result_src = 2'd1;
          reg_write = 1'b1;
        end
        MEMWRITE: begin
          adr_src = 1'b1;
          mem_write = 1'b1;
        end
        EXECR, EXECI: begin
          alu_src_a = 2'd2;
          alu_src_b = state == EXECI ? 2'd1 : 2'd0;
          alu_f = fn;
        end
        ALUWB: begin
          reg_write = 1'b1;
          alu_src_a = jalr_q ? 2'd1 : 2'd0;
          alu_src_b = jalr_q ? 2'd2 : 2'd0;
          result_src = jalr_q ? 2'd2 : 2'd0;
        end
        JAL: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          imm_src = 3'd3;
          pc_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 2'd2;
          alu_f = 3'd1;
          pc_write = funct3 == 3'b000 ? zero : funct3 == 3'b001 ? ~zero : 1'b0;
        end
        JALR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          pc_write = 1'b1;
        end
        LUI: begin
          imm_src = 3'd4;
          result_src = 2'd3;
          reg_write = 1'b1;
        end
        TRAP: illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    alu_control = ALU_CTRL_W'(alu_f);
  end
  // jalr_q marks the ALUWB that writes the JALR link value
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FETCH;
      jalr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      jalr_q <= state == JALR;
      done_q <= nxt == FETCH && state != FETCH;
    end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: table, directed and random checks against an instruction-level model
module tb_multi_cycle_controller;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         JL = 7'b1101111, BR = 7'b1100011, JR = 7'b1100111, LU = 7'b0110111;
  logic clk = 1'b0, rst = 1'b0, funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control, state;
  logic pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, instr_done0, illegal0;
  logic [1:0] result_src0, alu_src_a0, alu_src_b0;
  logic [2:0] imm_src0;
  logic [3:0] alu_control0, state0;
  logic [23:0] act, act0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.ALU_CTRL_W(4), .WAIT_EN(1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .state(state));

  multi_cycle_controller #(.ALU_CTRL_W(4), .WAIT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(1'b0), .pc_write(pc_write0), .adr_src(adr_src0), .mem_write(mem_write0),
    .ir_write(ir_write0), .reg_write(reg_write0), .instr_done(instr_done0), .illegal(illegal0),
    .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .imm_src(imm_src0), .alu_control(alu_control0), .state(state0));

  // {state, pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal,
  //  result_src, alu_src_a, alu_src_b, imm_src, alu_control}
  assign act = {state, pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control};
  assign act0 = {state0, pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, instr_done0,
                 illegal0, result_src0, alu_src_a0, alu_src_b0, imm_src0, alu_control0};

  typedef struct { logic [23:0] o; bit w; } step_t;
  typedef struct { logic [6:0] op; logic [2:0] f3; logic f7; logic z; int n; logic [23:0] seq; } vec_t;

  step_t plan[$];
  bit rdy_q[$];
  int alut[8] = '{0, 6, 5, 0, 4, 7, 3, 2};
  int dwell[16];
  int trap_cycles = 3;
  bit after_instr = 1'b0;
  logic [6:0] p_op;
  logic [2:0] p_f3;
  logic p_f7, p_z;

  task automatic chk(input string nm, input logic [23:0] a, input logic [23:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic step_t mk(input int st, pcw, adr, mw, rw, ill, rs, sa, sb, imm, alu, w);
    mk.o = {4'(st), 1'(pcw), 1'(adr), 1'(mw), 1'b0, 1'(rw), 1'b0, 1'(ill),
            2'(rs), 2'(sa), 2'(sb), 3'(imm), 4'(alu)};
    mk.w = w != 0;
  endfunction

  // One instruction expands into the list of control steps it must walk through
  task automatic plan_instr(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z);
    int pcw;
    p_op = o; p_f3 = f; p_f7 = f7; p_z = z;
    plan.delete();
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 1));
    plan.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0));
    if (o == LD || o == ST) begin
      plan.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, int'(o == ST), 0, 0));
      if (o == ST) plan.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      else begin
        plan.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        plan.push_back(mk(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      end
    end else if (o == RT || o == IT) begin
      if (o == RT) plan.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, (f == 3'd0 && f7) ? 1 : alut[f], 0));
      else plan.push_back(mk(8, 0, 0, 0, 0, 0, 0, 2, 1, 0, alut[f], 0));
      plan.push_back(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    end else if (o == JL) begin
      plan.push_back(mk(9, 1, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0));
      plan.push_back(mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    end else if (o == JR) begin
      plan.push_back(mk(11, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      plan.push_back(mk(7, 0, 0, 0, 1, 0, 2, 1, 2, 0, 0, 0));
    end else if (o == BR) begin
      pcw = f == 3'd0 ? int'(z) : f == 3'd1 ? int'(!z) : 0;
      plan.push_back(mk(10, pcw, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));
      if (f[2:1] != 2'b00) plan.push_back(mk(13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    end else if (o == LU) plan.push_back(mk(12, 0, 0, 0, 1, 0, 3, 0, 0, 4, 0, 0));
    else plan.push_back(mk(13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic run_plan();
    logic [23:0] e;
    int cyc;
    bit trap;
    for (int i = 0; i < plan.size(); i++) begin
      cyc = 0;
      trap = plan[i].o[23:20] == 4'd13;
      forever begin
        @(negedge clk);
        if (i == 0 && cyc == 0) begin op = p_op; funct3 = p_f3; funct7b5 = p_f7; zero = p_z; end
        mem_ready = rdy_q.size() > 0 ? rdy_q.pop_front() : ($urandom_range(0, 2) != 0);
        #1;
        e = plan[i].o;
        if (e[23:20] == 4'd0) begin
          e[19] = mem_ready;
          e[16] = mem_ready;
          e[14] = cyc == 0 && after_instr;
        end
        chk($sformatf("plan_st%0d_op%b", e[23:20], p_op), act, e);
        cyc++;
        if (trap ? cyc >= trap_cycles : (!plan[i].w || mem_ready)) break;
        if (cyc >= 64) begin
          checks++; errors++;
          $display("FAIL stall_bound: state %0d still waiting after %0d cycles", state, cyc);
          break;
        end
      end
      dwell[plan[i].o[23:20]] = cyc;
    end
    after_instr = plan[plan.size() - 1].o[23:20] != 4'd13;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1 chk("reset_outputs", act, 24'd0);
    chk("reset_outputs_nowait", act0, 24'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    after_instr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[12];
    logic [23:0] exp0[5];
    logic [6:0] ro;
    logic [2:0] rf;
    int s;
    tab = '{
      '{RT, 3'd0, 1'b1, 1'b0, 4, 24'h016700},
      '{IT, 3'd4, 1'b1, 1'b0, 4, 24'h018700},
      '{LD, 3'd2, 1'b0, 1'b0, 5, 24'h012340},
      '{ST, 3'd2, 1'b0, 1'b0, 4, 24'h012500},
      '{JL, 3'd0, 1'b0, 1'b0, 4, 24'h019700},
      '{JR, 3'd0, 1'b0, 1'b0, 4, 24'h01B700},
      '{LU, 3'd0, 1'b0, 1'b0, 3, 24'h01C000},
      '{BR, 3'd0, 1'b0, 1'b1, 3, 24'h01A000},
      '{BR, 3'd1, 1'b0, 1'b1, 3, 24'h01A000},
      '{BR, 3'd4, 1'b0, 1'b0, 4, 24'h01AD00},
      '{RT, 3'd3, 1'b0, 1'b0, 4, 24'h016D00},
      '{7'b1111111, 3'd0, 1'b0, 1'b0, 3, 24'h01D000}
    };
    do_reset();
    mem_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < tab[v].n; k++) begin
        @(negedge clk);
        if (k == 0) begin op = tab[v].op; funct3 = tab[v].f3; funct7b5 = tab[v].f7; zero = tab[v].z; end
        #1;
        chk($sformatf("tab%0d_state%0d", v, k), {20'd0, state}, {20'd0, tab[v].seq[23-4*k -: 4]});
        if (k == 0) chk($sformatf("tab%0d_done", v), {23'd0, instr_done}, {23'd0, after_instr});
      end
      if (tab[v].seq[23-4*(tab[v].n-1) -: 4] == 4'd13) begin
        chk($sformatf("tab%0d_illegal", v), {23'd0, illegal}, 24'd1);
        do_reset();
      end else after_instr = 1'b1;
    end
    plan_instr(LD, 3'd2, 1'b0, 1'b0);
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    run_plan();
    chk("load_stall_len", 24'(dwell[3]), 24'd4);
    plan_instr(BR, 3'd1, 1'b0, 1'b0);
    run_plan();
    plan_instr(BR, 3'd1, 1'b0, 1'b1);
    run_plan();
    plan_instr(JR, 3'd0, 1'b0, 1'b0);
    run_plan();
    trap_cycles = 10;
    plan_instr(7'b1111111, 3'd0, 1'b0, 1'b0);
    run_plan();
    chk("trap_len", 24'(dwell[13]), 24'd10);
    do_reset();
    trap_cycles = 3;
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin op = ST; funct3 = 3'd2; end
      if (k == 3) mem_ready = 1'b0;
      #1;
    end
    chk("store_stalled", act, mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0).o);
    do_reset();
    exp0[0] = mk(0, 1, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0).o | 24'h010000;
    exp0[1] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0).o;
    exp0[2] = mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0).o;
    exp0[3] = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0).o;
    exp0[4] = exp0[0] | 24'h004000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin op = ST; funct3 = 3'd2; mem_ready = 1'b0; end
      #1 chk($sformatf("nowait_store%0d", k), act0, exp0[k]);
    end
    do_reset();
    for (int n = 0; n < 60; n++) begin
      s = $urandom_range(0, 9);
      ro = s < 8 ? (s == 0 ? LD : s == 1 ? ST : s == 2 ? RT : s == 3 ? IT :
                    s == 4 ? JL : s == 5 ? BR : s == 6 ? JR : LU) : 7'($urandom);
      rf = 3'($urandom);
      if ((ro == RT || ro == IT) && rf == 3'b011) rf = 3'b000;
      plan_instr(ro, rf, 1'($urandom), 1'($urandom));
      run_plan();
      if (!after_instr) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
